swc_param: RTL and testbench

//  Parametrised successor of the 24-bit instruction-driven switch counter. Holds a BYTES*8-bit

---
 rtl/swc_param_pkg.sv | 44 ++++
 rtl/swc_param_if.sv | 12 +
 rtl/swc_param_step.sv | 20 ++
 rtl/swc_param.sv | 126 ++++++++++++
 tb/tb_swc_param.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/swc_param_pkg.sv
// Shared opcode map, FSM/continuous-count encodings and lane decode helpers
// for the switch counter, its sequencer and bench.
package swc_param_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LD0 = 4'h1;
  localparam logic [3:0] OP_LD1 = 4'h2;
  localparam logic [3:0] OP_LD2 = 4'h3;
  localparam logic [3:0] OP_COU = 4'h4;
  localparam logic [3:0] OP_COD = 4'h5;
  localparam logic [3:0] OP_CCU = 4'h6;
  localparam logic [3:0] OP_CCD = 4'h7;
  localparam logic [3:0] OP_CCS = 4'h8;
  localparam logic [3:0] OP_LD3 = 4'h9;
  localparam logic [3:0] OP_TL0 = 4'hA;
  localparam logic [3:0] OP_TL1 = 4'hB;
  localparam logic [3:0] OP_TL2 = 4'hC;
  localparam logic [3:0] OP_TL3 = 4'hD;
  localparam logic [3:0] OP_CLR = 4'hE;
  localparam logic [3:0] OP_CLE = 4'hF;

  typedef enum logic [1:0] {ST_RESET, ST_READY, ST_ERROR} state_e;
  typedef enum logic [1:0] {CONT_NOP, CONT_CCU, CONT_CCD} cont_e;

  // LD opcodes are not contiguous (LD3 sits at 9), so lanes are decoded explicitly.
  function automatic logic [1:0] ld_lane(input logic [3:0] op);
    case (op)
      OP_LD1:  return 2'd1;
      OP_LD2:  return 2'd2;
      OP_LD3:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] tl_lane(input logic [3:0] op);
    case (op)
      OP_TL1:  return 2'd1;
      OP_TL2:  return 2'd2;
      OP_TL3:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/swc_param_if.sv
// Instruction/status bundle between the sequencer (master) and the counter (slave).
interface swc_param_if #(parameter int unsigned BYTES = 3);
  logic [11:0]          inst;
  logic                 inst_en;
  logic [8*BYTES-1:0]   counter;
  logic                 ready;
  logic                 busy;
  logic                 error;

  modport master (output inst, inst_en, input counter, ready, busy, error);
  modport slave  (input inst, inst_en, output counter, ready, busy, error);
endinterface

// File: rtl/swc_param_step.sv
// One +1/-1 step of the counter, either wrapping modulo 2^W or saturating.
module swc_step #(
  parameter int unsigned W    = 24,
  parameter bit          WRAP = 1'b1
) (
  input  logic         dir,       // 0: up, 1: down
  input  logic [W-1:0] value,
  output logic [W-1:0] next,
  output logic         at_limit
);

  always_comb begin
    if (WRAP) at_limit = 1'b0;
    else      at_limit = dir ? (value == '0) : (value == '1);
    if (at_limit)  next = value;
    else if (dir)  next = value - W'(1);
    else           next = value + W'(1);
  end

endmodule

// File: rtl/swc_param.sv
// Parametrised instruction-driven switch counter with programmable stop target,
// wrap/saturate stepping, busy/error status and CLE recovery.
module swc_param
  import swc_param_pkg::*;
#(
  parameter int unsigned BYTES = 3,
  parameter bit          WRAP  = 1'b1
) (
  input  logic      clock,
  input  logic      reset,
  swc_param_if.slave bus
);

  localparam int unsigned W = 8 * BYTES;

  state_e         state_q, state_n;
  cont_e          cont_q, cont_n;
  logic [W-1:0]   cnt_q, cnt_n, tgt_q, tgt_n;
  logic [W-1:0]   cnt_ld, tgt_ld, step_val;
  logic           busy_q, busy_n, err_q, err_n, rdy_q, rdy_n;
  logic [3:0]     op;
  logic [7:0]     imm;
  logic [1:0]     ld_idx, tl_idx;
  logic           cmd, step_dn, step_lim;

  assign op     = bus.inst[11:8];
  assign imm    = bus.inst[7:0];
  assign ld_idx = ld_lane(op);
  assign tl_idx = tl_lane(op);
  assign cmd    = (state_q == ST_READY) && bus.inst_en;

  // Lanes at or above BYTES never match, so an out-of-range load leaves these equal to the held value.
  for (genvar b = 0; b < BYTES; b++) begin : g_lane
    assign cnt_ld[b*8 +: 8] = (ld_idx == 2'(b)) ? imm : cnt_q[b*8 +: 8];
    assign tgt_ld[b*8 +: 8] = (tl_idx == 2'(b)) ? imm : tgt_q[b*8 +: 8];
  end

  assign step_dn = cmd ? ((op == OP_COD) || (op == OP_CCD)) : (cont_q == CONT_CCD);

  swc_step #(.W(W), .WRAP(WRAP)) u_step (
    .dir      (step_dn),
    .value    (cnt_q),
    .next     (step_val),
    .at_limit (step_lim)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_RESET;
      cont_q  <= CONT_NOP;
      cnt_q   <= '0;
      tgt_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_n;
      cont_q  <= cont_n;
      cnt_q   <= cnt_n;
      tgt_q   <= tgt_n;
      busy_q  <= busy_n;
      err_q   <= err_n;
      rdy_q   <= rdy_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cont_n  = cont_q;
    cnt_n   = cnt_q;
    tgt_n   = tgt_q;
    case (state_q)
      ST_RESET: state_n = ST_READY;
      ST_READY: begin
        if (bus.inst_en) begin
          // Every accepted instruction cancels a running count unless it starts a new one.
          cont_n = CONT_NOP;
          case (op)
            OP_LD0, OP_LD1, OP_LD2, OP_LD3: begin
              if (32'(ld_idx) >= BYTES) state_n = ST_ERROR;
              else                      cnt_n   = cnt_ld;
            end
            OP_TL0, OP_TL1, OP_TL2, OP_TL3: begin
              if (32'(tl_idx) >= BYTES) state_n = ST_ERROR;
              else                      tgt_n   = tgt_ld;
            end
            OP_COU, OP_COD: cnt_n = step_val;
            OP_CCU: begin
              cnt_n  = step_val;
              cont_n = CONT_CCU;
            end
            OP_CCD: begin
              cnt_n  = step_val;
              cont_n = CONT_CCD;
            end
            OP_CLR:  cnt_n = '0;
            default: ;
          endcase
        end else if (cont_q != CONT_NOP) begin
          if ((cnt_q == tgt_q) || step_lim) cont_n = CONT_NOP;
          else                              cnt_n  = step_val;
        end
      end
      ST_ERROR: begin
        if (bus.inst_en && (op == OP_CLE)) begin
          state_n = ST_READY;
          cnt_n   = '0;
          cont_n  = CONT_NOP;
        end
      end
      default: state_n = ST_RESET;
    endcase
  end

  always_comb begin
    busy_n = (state_n == ST_READY) && (cont_n != CONT_NOP);
    err_n  = (state_n == ST_ERROR);
    rdy_n  = (cnt_n == tgt_n);
  end

  assign bus.counter = cnt_q;
  assign bus.ready   = rdy_q;
  assign bus.busy    = busy_q;
  assign bus.error   = err_q;

endmodule

// File: tb/tb_swc_param.sv
// Scoreboard bench: a wrapping and a saturating 16-bit counter driven with
// directed instructions; expected status is queued and checked one cycle later.
module tb_swc_param;
  import swc_param_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  swc_param_if #(.BYTES(2)) bw ();
  swc_param_if #(.BYTES(2)) bs ();

  swc_param #(.BYTES(2), .WRAP(1'b1)) u_wrap (.clock(clock), .reset(reset), .bus(bw.slave));
  swc_param #(.BYTES(2), .WRAP(1'b0)) u_sat  (.clock(clock), .reset(reset), .bus(bs.slave));

  typedef struct {
    int          due;
    bit          dut;
    logic [15:0] c;
    logic        r, b, e;
    bit          chk_b;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t m_x;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Drive one cycle on DUT d (the other DUT idles) and queue the state expected after the edge.
  task automatic go(input logic rst, input bit d, input logic en, input logic [3:0] op,
                    input logic [7:0] imm, input string nm, input logic [15:0] c,
                    input logic r, input logic b, input logic e, input bit chk_b = 1'b1);
    exp_t x;
    @(negedge clock);
    reset      = rst;
    bw.inst_en = 1'b0;
    bs.inst_en = 1'b0;
    if (d) begin
      bs.inst    = {op, imm};
      bs.inst_en = en;
    end else begin
      bw.inst    = {op, imm};
      bw.inst_en = en;
    end
    x.due   = cyc + 1;
    x.dut   = d;
    x.c     = c;
    x.r     = r;
    x.b     = b;
    x.e     = e;
    x.chk_b = chk_b;
    x.name  = nm;
    sb.push_back(x);
  endtask

  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      logic [15:0] ac;
      logic        ar, ab, ae;
      m_x = sb.pop_front();
      ac  = m_x.dut ? bs.counter : bw.counter;
      ar  = m_x.dut ? bs.ready   : bw.ready;
      ab  = m_x.dut ? bs.busy    : bw.busy;
      ae  = m_x.dut ? bs.error   : bw.error;
      n_cmp++;
      if ((ac !== m_x.c) || (ar !== m_x.r) || (ae !== m_x.e) || (m_x.chk_b && (ab !== m_x.b))) begin
        n_bad++;
        $display("FAIL %s: got counter=%h ready=%b busy=%b error=%b, want counter=%h ready=%b busy=%b error=%b",
                 m_x.name, ac, ar, ab, ae, m_x.c, m_x.r, m_x.b, m_x.e);
      end
    end
  end

  initial begin
    reset      = 1'b0;
    bw.inst    = '0;
    bw.inst_en = 1'b0;
    bs.inst    = '0;
    bs.inst_en = 1'b0;

    // reset and first free cycle
    go(0, 0, 0, OP_NOP, 8'h00, "rst_a",         16'h0000, 1, 0, 0);
    go(0, 0, 1, OP_COU, 8'h00, "rst_b",         16'h0000, 1, 0, 0);
    go(1, 0, 1, OP_LD0, 8'h55, "first_ignored", 16'h0000, 1, 0, 0);
    go(1, 0, 1, OP_LD0, 8'h55, "ld0",           16'h0055, 0, 0, 0);
    // continuous count up to target 5
    go(1, 0, 1, OP_TL0, 8'h05, "tl0",           16'h0055, 0, 0, 0);
    go(1, 0, 1, OP_CLR, 8'h00, "clr",           16'h0000, 0, 0, 0);
    go(1, 0, 1, OP_CCU, 8'h00, "ccu_1",         16'h0001, 0, 1, 0);
    go(1, 0, 0, OP_NOP, 8'h00, "ccu_2",         16'h0002, 0, 1, 0);
    go(1, 0, 0, OP_NOP, 8'h00, "ccu_3",         16'h0003, 0, 1, 0);
    go(1, 0, 0, OP_NOP, 8'h00, "ccu_4",         16'h0004, 0, 1, 0);
    go(1, 0, 0, OP_NOP, 8'h00, "ccu_5",         16'h0005, 1, 1, 0);
    go(1, 0, 0, OP_NOP, 8'h00, "ccu_done",      16'h0005, 1, 0, 0);
    // wrap
    go(1, 0, 1, OP_LD1, 8'hFF, "ld1_ff",        16'hFF05, 0, 0, 0);
    go(1, 0, 1, OP_LD0, 8'hFF, "ld0_ff",        16'hFFFF, 0, 0, 0);
    go(1, 0, 1, OP_COU, 8'h00, "cou_wrap",      16'h0000, 0, 0, 0);
    go(1, 0, 1, OP_COD, 8'h00, "cod_wrap",      16'hFFFF, 0, 0, 0);
    // error and recovery
    go(1, 0, 1, OP_LD2, 8'h11, "ld2_err",       16'hFFFF, 0, 0, 1);
    go(1, 0, 1, OP_COU, 8'h00, "err_cou",       16'hFFFF, 0, 0, 1);
    go(1, 0, 1, OP_CLE, 8'h00, "cle",           16'h0000, 0, 0, 0);
    go(1, 0, 1, OP_LD0, 8'h05, "tgt_kept",      16'h0005, 1, 0, 0);
    go(1, 0, 1, OP_TL2, 8'h11, "tl2_err",       16'h0005, 1, 0, 1);
    go(1, 0, 1, OP_CLE, 8'h00, "cle_2",         16'h0000, 0, 0, 0);
    // count down, stop, reverse
    go(1, 0, 1, OP_TL0, 8'h00, "tl0_zero",      16'h0000, 1, 0, 0);
    go(1, 0, 1, OP_LD0, 8'h10, "ld0_10",        16'h0010, 0, 0, 0);
    go(1, 0, 1, OP_CCD, 8'h00, "ccd_1",         16'h000F, 0, 1, 0);
    go(1, 0, 0, OP_NOP, 8'h00, "ccd_2",         16'h000E, 0, 1, 0);
    go(1, 0, 0, OP_NOP, 8'h00, "ccd_3",         16'h000D, 0, 1, 0);
    go(1, 0, 1, OP_CCS, 8'h00, "ccs",           16'h000D, 0, 0, 0);
    go(1, 0, 0, OP_NOP, 8'h00, "ccs_hold",      16'h000D, 0, 0, 0);
    go(1, 0, 1, OP_CCU, 8'h00, "rev_ccu",       16'h000E, 0, 1, 0);
    go(1, 0, 1, OP_CCD, 8'h00, "rev_ccd",       16'h000D, 0, 1, 0);
    go(1, 0, 0, OP_NOP, 8'h00, "rev_run",       16'h000C, 0, 1, 0);
    go(0, 0, 1, OP_COU, 8'h00, "mid_reset",     16'h0000, 1, 0, 0);
    go(1, 0, 1, OP_LD0, 8'h77, "post_rst_ign",  16'h0000, 1, 0, 0);
    go(1, 0, 1, OP_LD0, 8'h33, "ld0_33",        16'h0033, 0, 0, 0);
    go(1, 0, 1, OP_CLE, 8'h00, "cle_ready",     16'h0033, 0, 0, 0);
    // saturating instance
    go(1, 1, 1, OP_TL1, 8'h12, "s_tl1",         16'h0000, 0, 0, 0);
    go(1, 1, 1, OP_TL0, 8'h34, "s_tl0",         16'h0000, 0, 0, 0);
    go(1, 1, 1, OP_LD1, 8'hFF, "s_ld1",         16'hFF00, 0, 0, 0);
    go(1, 1, 1, OP_LD0, 8'hFE, "s_ld0",         16'hFFFE, 0, 0, 0);
    go(1, 1, 1, OP_CCU, 8'h00, "s_ccu",         16'hFFFF, 0, 1, 0, 1'b0);
    go(1, 1, 0, OP_NOP, 8'h00, "s_stop",        16'hFFFF, 0, 0, 0);
    go(1, 1, 0, OP_NOP, 8'h00, "s_hold",        16'hFFFF, 0, 0, 0);
    go(1, 1, 1, OP_COU, 8'h00, "s_cou_top",     16'hFFFF, 0, 0, 0);
    go(1, 1, 1, OP_CLR, 8'h00, "s_clr",         16'h0000, 0, 0, 0);
    go(1, 1, 1, OP_COD, 8'h00, "s_cod_bot",     16'h0000, 0, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
    while (sb.size() > 0) begin
      m_x = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no check within budget, want counter=%h", m_x.name, m_x.c);
    end

    n_cmp++;
    if (bs.counter !== 16'h0000) begin
      n_bad++;
      $display("FAIL s_final_cnt: got counter=%h, want 0000", bs.counter);
    end
    n_cmp++;
    if ((bs.ready !== 1'b0) || (bs.busy !== 1'b0) || (bs.error !== 1'b0)) begin
      n_bad++;
      $display("FAIL s_final_status: got ready=%b busy=%b error=%b, want 0/0/0",
               bs.ready, bs.busy, bs.error);
    end
    n_cmp++;
    if (bw.counter !== 16'h0033) begin
      n_bad++;
      $display("FAIL w_final_cnt: got counter=%h, want 0033", bw.counter);
    end
    n_cmp++;
    if ((bw.busy !== 1'b0) || (bw.error !== 1'b0)) begin
      n_bad++;
      $display("FAIL w_final_status: got busy=%b error=%b, want 0/0", bw.busy, bw.error);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
